eco_equiv_driver: RTL and testbench

ECO_EQUIV_DRIVER -- requirements
Module: eco_equiv_driver

---
 rtl/eco_equiv_driver.sv | 139 +++++++++++++
 tb/tb_eco_equiv_driver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/eco_equiv_driver.sv
// Sweeps every A/B operand pair into two netlists, compares their responses and
// compacts the revised netlist's response into a 16-bit MISR signature.
module eco_equiv_driver #(
  parameter int unsigned LAST_IDX  = 1023,
  parameter logic [15:0] MISR_POLY = 16'hB400,
  parameter logic [15:0] MISR_SEED = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  A,
  output logic [4:0]  B,
  input  logic [2:0]  Y_gold,
  input  logic [2:0]  Y_rev,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [10:0] mismatch_cnt,
  output logic [9:0]  first_fail_idx,
  output logic        first_fail_vld,
  output logic [15:0] signature
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [9:0] LAST_IDX_C = 10'(LAST_IDX);

  state_t      state_r;
  logic [9:0]  idx_r;
  logic        busy_r;
  logic        done_r;
  logic        pass_r;
  logic [10:0] cnt_r;
  logic [9:0]  ffi_r;
  logic        ffv_r;
  logic [15:0] sig_r;

  logic        mismatch_s;
  logic        last_s;
  logic [10:0] cnt_next_s;
  logic [15:0] sig_next_s;

  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [2:0] y);
    logic [15:0] fb;
    if (sig[15]) begin
      fb = MISR_POLY;
    end else begin
      fb = 16'h0000;
    end
    return ({sig[14:0], 1'b0} ^ fb) ^ {13'd0, y};
  endfunction

  // Compare result and next-state values for the pattern currently being sampled.
  always_comb begin
    mismatch_s = 1'b0;
    if (Y_gold != Y_rev) begin
      mismatch_s = 1'b1;
    end else begin
      mismatch_s = 1'b0;
    end
    last_s     = (idx_r == LAST_IDX_C);
    cnt_next_s = cnt_r + {10'd0, mismatch_s};
    sig_next_s = misr_step(sig_r, Y_rev);
  end

  // Sequencer: DRIVE gives the netlists one settling cycle, SAMPLE compares on exit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 10'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      cnt_r   <= 11'd0;
      ffi_r   <= 10'd0;
      ffv_r   <= 1'b0;
      sig_r   <= MISR_SEED;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r <= DRIVE;
            idx_r   <= 10'd0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            cnt_r   <= 11'd0;
            ffi_r   <= 10'd0;
            ffv_r   <= 1'b0;
            sig_r   <= MISR_SEED;
          end else begin
            state_r <= state_r;
          end
        end
        DRIVE: begin
          state_r <= SAMPLE;
        end
        SAMPLE: begin
          cnt_r <= cnt_next_s;
          sig_r <= sig_next_s;
          if (mismatch_s && !ffv_r) begin
            ffi_r <= idx_r;
            ffv_r <= 1'b1;
          end else begin
            ffv_r <= ffv_r;
          end
          if (last_s) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (cnt_next_s == 11'd0);
          end else begin
            state_r <= DRIVE;
            idx_r   <= idx_r + 10'd1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign A              = idx_r[4:0];
  assign B              = idx_r[9:5];
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign mismatch_cnt   = cnt_r;
  assign first_fail_idx = ffi_r;
  assign first_fail_vld = ffv_r;
  assign signature      = sig_r;

endmodule

// File: tb/tb_eco_equiv_driver.sv
// Bench for eco_equiv_driver: modelled gold/revised netlists with injectable faults,
// a scoreboard of expected run results, plus a LAST_IDX=0 instance.
module tb_eco_equiv_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  A, B;
  logic [2:0]  Y_gold, Y_rev;
  logic        busy, done, pass, first_fail_vld;
  logic [10:0] mismatch_cnt;
  logic [9:0]  first_fail_idx;
  logic [15:0] signature;

  logic        start0 = 1'b0;
  logic [4:0]  a0, b0;
  logic        busy0, done0, pass0, ffv0;
  logic [10:0] cnt0;
  logic [9:0]  ffi0;
  logic [15:0] sig0;

  logic [1:0]  mode = 2'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [10:0] exp_cnt;
    logic [9:0]  exp_ffi;
    logic        exp_ffv;
    logic        exp_pass;
  } vec_t;

  typedef struct {
    logic [10:0] cnt;
    logic [9:0]  ffi;
    logic        ffv;
    logic        pass;
    logic [15:0] sig;
  } res_t;

  res_t sb_q[$];

  function automatic logic [2:0] gold_f(input logic [4:0] a, input logic [4:0] b);
    return a[2:0] ^ {b[1:0], b[4]} ^ {2'b00, a[3] & b[3]};
  endfunction

  function automatic logic [2:0] fault_f(input logic [1:0] m, input logic [4:0] a, input logic [4:0] b);
    case (m)
      2'd1:    return (a == 5'd3 && b == 5'd0) ? 3'b001 : 3'b000;
      2'd2:    return (b == 5'd31) ? 3'b111 : 3'b000;
      2'd3:    return (a == b) ? 3'b100 : 3'b000;
      default: return 3'b000;
    endcase
  endfunction

  assign Y_gold = gold_f(A, B);
  assign Y_rev  = Y_gold ^ fault_f(mode, A, B);

  eco_equiv_driver dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .Y_gold(Y_gold), .Y_rev(Y_rev), .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .first_fail_idx(first_fail_idx),
    .first_fail_vld(first_fail_vld), .signature(signature)
  );

  eco_equiv_driver #(.LAST_IDX(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .A(a0), .B(b0),
    .Y_gold(3'd0), .Y_rev(3'd0), .busy(busy0), .done(done0), .pass(pass0),
    .mismatch_cnt(cnt0), .first_fail_idx(ffi0),
    .first_fail_vld(ffv0), .signature(sig0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected signature from the MISR recurrence applied to the modelled netlists.
  function automatic logic [15:0] model_sig(input logic [1:0] m);
    logic [15:0] s;
    logic [4:0]  a, b;
    logic [2:0]  yr;
    s = 16'hFFFF;
    for (int i = 0; i < 1024; i++) begin
      a  = 5'(i);
      b  = 5'(i >> 5);
      yr = gold_f(a, b) ^ fault_f(m, a, b);
      s  = {s[14:0], 1'b0} ^ (s[15] ? 16'hB400 : 16'h0000) ^ {13'd0, yr};
    end
    return s;
  endfunction

  task automatic start_run(input vec_t v);
    res_t r;
    mode   = v.mode;
    r.cnt  = v.exp_cnt;
    r.ffi  = v.exp_ffi;
    r.ffv  = v.exp_ffv;
    r.pass = v.exp_pass;
    r.sig  = model_sig(v.mode);
    sb_q.push_back(r);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int repulse_at, output int n);
    int bad_busy;
    n = 0;
    bad_busy = 0;
    while (n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) break;
      if (!busy) bad_busy++;
      start = (n == repulse_at);
    end
    start = 1'b0;
    chk("busy_during_run", 32'(bad_busy), 32'd0);
    chk("run_length", 32'(n), 32'd2048);
  endtask

  task automatic check_run(input string tag);
    res_t e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_cnt"}, 32'(mismatch_cnt), 32'(e.cnt));
    chk({tag, "_ffv"}, 32'(first_fail_vld), 32'(e.ffv));
    if (e.ffv) chk({tag, "_ffi"}, 32'(first_fail_idx), 32'(e.ffi));
    chk({tag, "_pass"}, 32'(pass), 32'(e.pass));
    chk({tag, "_sig"}, 32'(signature), 32'(e.sig));
    chk({tag, "_ab_hold"}, 32'({A, B}), 32'h3FF);
    repeat (3) @(negedge clk);
    chk({tag, "_stable"}, 32'({done, pass, mismatch_cnt, signature}),
        32'({1'b1, e.pass, e.cnt, e.sig}));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ctrl"}, 32'({busy, done, pass, first_fail_vld}), 32'd0);
    chk({tag, "_ab"}, 32'({A, B}), 32'd0);
    chk({tag, "_cnt_ffi"}, 32'({mismatch_cnt, first_fail_idx}), 32'd0);
    chk({tag, "_sig"}, 32'(signature), 32'hFFFF);
  endtask

  vec_t vecs[4];

  initial begin
    int n;
    vecs[0] = '{mode: 2'd0, exp_cnt: 11'd0,  exp_ffi: 10'd0,   exp_ffv: 1'b0, exp_pass: 1'b1};
    vecs[1] = '{mode: 2'd1, exp_cnt: 11'd1,  exp_ffi: 10'd3,   exp_ffv: 1'b1, exp_pass: 1'b0};
    vecs[2] = '{mode: 2'd2, exp_cnt: 11'd32, exp_ffi: 10'd992, exp_ffv: 1'b1, exp_pass: 1'b0};
    vecs[3] = '{mode: 2'd3, exp_cnt: 11'd32, exp_ffi: 10'd0,   exp_ffv: 1'b1, exp_pass: 1'b0};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_state("reset");

    // Back-to-back runs; every start after the first is accepted from DONE.
    for (int i = 0; i < 4; i++) begin
      start_run(vecs[i]);
      wait_done(0, n);
      check_run($sformatf("vec%0d", i));
    end

    // Start re-pulsed mid-run must not restart the sweep.
    start_run(vecs[2]);
    wait_done(100, n);
    check_run("repulse");

    // Reset mid-run, then a clean full run.
    start_run(vecs[1]);
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_state("abort");
    void'(sb_q.pop_front());
    repeat (2) @(negedge clk);
    chk("abort_idle", 32'({busy, done}), 32'd0);
    start_run(vecs[1]);
    wait_done(0, n);
    check_run("after_abort");

    // Single-pattern instance.
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    n = 0;
    while (n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done0) break;
    end
    chk("last0_len", 32'(n), 32'd2);
    chk("last0_sig", 32'(sig0), 32'h4BFE);
    chk("last0_pass", 32'({pass0, busy0, ffv0}), 32'b100);
    chk("last0_ab_cnt", 32'({a0, b0, cnt0}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
